// File: rtl/mips8_pkg.sv
// ---------------------------------------------------------------------------
// mips8_pkg
//   Shared definitions for the MIPS8 interrupt source block.
//   - intr_state_t : handshake state of the interrupt controller
//   - CFG_*        : config register addresses on the data-memory bus
//   - vec_addr()   : handler address for a given source line
// ---------------------------------------------------------------------------
package mips8_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } intr_state_t;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_PEND = 2'd1;
    localparam logic [1:0] CFG_IE   = 2'd2;

    // Each handler slot is two bytes wide; the sum wraps modulo 256.
    function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [2:0] idx);
        return base + {4'b0000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// ---------------------------------------------------------------------------
// intr_prio_enc
//   Combinational fixed-priority encoder, lowest set index wins.
//   Ports:
//     req   in  NUM_SRC  request vector
//     valid out 1        at least one request bit set
//     index out 3        index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module intr_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [2:0]         index
);

    always_comb begin
        valid = |req;
        index = 3'd0;
        // Scan downward so the lowest set bit is the last to assign.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
//   Interrupt source side of the MIPS8 controller's 2-bit INTR input.
//   Collects NUM_SRC device lines, latches pending requests, picks the
//   lowest-index eligible line and presents INTR plus a handler vector.
//   Line 0 is non-maskable (NMI) and ignores MASK and IE.
//
//   Build option: define INTR_EDGE_EN for edge-triggered capture (pending
//   bits latch on irq rising edges and clear on ack or PEND write-1-to-clear).
//   Without it capture is level-sensitive: pending follows irq directly.
//
//   Ports:
//     clk        in   1        system clock
//     rst        in   1        synchronous active-high reset
//     irq        in   NUM_SRC  device request lines
//     intr_ack   in   1        controller entered the handler (pulse)
//     intr_done  in   1        controller executed RETI (pulse)
//     cfg_we     in   1        config write strobe
//     cfg_addr   in   2        0=MASK 1=PEND(W1C) 2=IE 3=reserved
//     cfg_wdata  in   8        config write data
//     cfg_rdata  out  8        combinational config read
//     INTR       out  2        [1]=NMI request, [0]=maskable request
//     intr_vec   out  8        handler address, held until intr_done
// ---------------------------------------------------------------------------
module intr_ctrl
    import mips8_pkg::*;
#(
    parameter int          NUM_SRC  = 4,
    parameter logic [7:0]  VEC_BASE = 8'hF0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               intr_ack,
    input  logic               intr_done,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata,
    output logic [1:0]         INTR,
    output logic [7:0]         intr_vec
);

    intr_state_t        state_reg;
    logic [NUM_SRC-1:0] mask_reg;
    logic               ie_reg;
    logic               ie_sv_reg;
    logic [2:0]         sel_reg;
    logic [1:0]         intr_reg;
    logic [7:0]         vec_reg;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] en_vec;
    logic [NUM_SRC-1:0] elig;
    logic               win_valid;
    logic [2:0]         win_idx;

    logic ie_wr;
    logic take_ack;
    logic take_done;
    logic ie_in;
    logic ie_sv_in;

    assign ie_wr     = cfg_we && (cfg_addr == CFG_IE);
    assign take_ack  = (state_reg == REQUEST) && intr_ack;
    // A simultaneous ack is irrelevant here: ack only counts in REQUEST.
    assign take_done = (state_reg == IN_SERVICE) && intr_done;

    // Value IE would hold this cycle including a same-cycle write, so that
    // a write racing an ack or done is not lost.
    assign ie_in    = ie_wr ? cfg_wdata[0] : ie_reg;
    assign ie_sv_in = ie_wr ? cfg_wdata[0] : ie_sv_reg;

`ifdef INTR_EDGE_EN
    logic               pend_wr;
    logic [NUM_SRC-1:0] irq_q_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] pending_next;
    logic               unused_sink;

    assign pend_wr     = cfg_we && (cfg_addr == CFG_PEND);
    assign unused_sink = ^cfg_wdata;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            localparam logic [2:0] IDX = 3'(gi);
            // A new edge beats any clear arriving in the same cycle.
            assign pending_next[gi] =
                (irq[gi] && !irq_q_reg[gi]) ? 1'b1 :
                ((pend_wr && cfg_wdata[gi]) || (take_ack && (sel_reg == IDX))) ? 1'b0 :
                pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q_reg   <= '0;
            pending_reg <= '0;
        end else begin
            irq_q_reg   <= irq;
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;
`else
    logic unused_sink;

    // Level mode never clears by line, so the granted index is informational.
    assign unused_sink = ^{cfg_wdata, sel_reg};
    assign pending     = irq;
`endif

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_elig
            if (gi == 0) begin : g_nmi
                assign en_vec[gi] = 1'b1;
            end else begin : g_mask
                assign en_vec[gi] = mask_reg[gi] & ie_reg;
            end
        end
    endgenerate

    assign elig = pending & en_vec;

    intr_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req   (elig),
        .valid (win_valid),
        .index (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            ie_reg    <= 1'b0;
            ie_sv_reg <= 1'b0;
            sel_reg   <= 3'd0;
            intr_reg  <= 2'b00;
            vec_reg   <= 8'h00;
        end else begin
            if (cfg_we && (cfg_addr == CFG_MASK)) begin
                mask_reg <= cfg_wdata[NUM_SRC-1:0];
            end

            // While a handler runs, IE writes target the saved copy so the
            // handler cannot re-open nesting; RETI restores it.
            if (ie_wr) begin
                if (state_reg == IN_SERVICE) begin
                    ie_sv_reg <= cfg_wdata[0];
                end else begin
                    ie_reg <= cfg_wdata[0];
                end
            end

            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        state_reg <= REQUEST;
                        sel_reg   <= win_idx;
                        intr_reg  <= {win_idx == 3'd0, win_idx != 3'd0};
                        vec_reg   <= vec_addr(VEC_BASE, win_idx);
                    end
                end
                REQUEST: begin
                    // Request is committed: no re-arbitration, no withdrawal.
                    if (take_ack) begin
                        state_reg <= IN_SERVICE;
                        intr_reg  <= 2'b00;
                        ie_sv_reg <= ie_in;
                        ie_reg    <= 1'b0;
                    end
                end
                IN_SERVICE: begin
                    if (take_done) begin
                        state_reg <= IDLE;
                        ie_reg    <= ie_sv_in;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cfg_rdata = 8'h00;
        case (cfg_addr)
            CFG_MASK: cfg_rdata = 8'(mask_reg);
            CFG_PEND: cfg_rdata = 8'(pending);
            CFG_IE:   cfg_rdata = {7'b0000000, ie_reg};
            default:  cfg_rdata = 8'h00;
        endcase
    end

    assign INTR     = intr_reg;
    assign intr_vec = vec_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
//   Directed stimulus for intr_ctrl (NUM_SRC=4, VEC_BASE=8'hF0) with a
//   behavioural reference model compared on every falling edge, plus literal
//   expectations at the key points of each scenario. Works for both capture
//   modes selected by INTR_EDGE_EN.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

`ifdef INTR_EDGE_EN
    localparam int LAT  = 2;
    localparam bit EDGE = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       intr_ack;
    logic       intr_done;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic [1:0] INTR;
    logic [7:0] intr_vec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    intr_ctrl #(
        .NUM_SRC  (4),
        .VEC_BASE (8'hF0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .intr_ack  (intr_ack),
        .intr_done (intr_done),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .INTR      (INTR),
        .intr_vec  (intr_vec)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = nothing outstanding, 1 = request shown awaiting ack,
    //        2 = handler running awaiting RETI
    logic [3:0] m_pend;
    logic [3:0] m_irq_q;
    logic [3:0] m_mask;
    logic       m_ie;
    logic       m_ie_sv;
    int         m_phase;
    int         m_line;
    logic [7:0] m_vec;
    bit         m_valid = 1'b0;

    function automatic logic [3:0] cur_pend();
        return EDGE ? m_pend : irq;
    endfunction

    function automatic int winner(input logic [3:0] p, input logic [3:0] m, input logic ie);
        int w = -1;
        for (int i = 3; i >= 0; i--) begin
            if (p[i] && (i == 0 || (m[i] && ie))) w = i;
        end
        return w;
    endfunction

    function automatic logic [3:0] next_pend();
        logic [3:0] np;
        for (int i = 0; i < 4; i++) begin
            np[i] = m_pend[i];
            if (cfg_we && cfg_addr == 2'd1 && cfg_wdata[i]) np[i] = 1'b0;
            if (m_phase == 1 && intr_ack && m_line == i) np[i] = 1'b0;
            if (irq[i] && !m_irq_q[i]) np[i] = 1'b1;
        end
        return np;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend  <= 4'h0;
            m_irq_q <= 4'h0;
            m_mask  <= 4'h0;
            m_ie    <= 1'b0;
            m_ie_sv <= 1'b0;
            m_phase <= 0;
            m_line  <= 0;
            m_vec   <= 8'h00;
            m_valid <= 1'b1;
        end else begin
            m_irq_q <= irq;
            m_pend  <= next_pend();
            if (cfg_we && cfg_addr == 2'd0) m_mask <= cfg_wdata[3:0];
            case (m_phase)
                0: begin
                    if (cfg_we && cfg_addr == 2'd2) m_ie <= cfg_wdata[0];
                    if (winner(cur_pend(), m_mask, m_ie) >= 0) begin
                        m_phase <= 1;
                        m_line  <= winner(cur_pend(), m_mask, m_ie);
                        m_vec   <= 8'hF0 + 8'(2 * winner(cur_pend(), m_mask, m_ie));
                    end
                end
                1: begin
                    if (intr_ack) begin
                        m_ie_sv <= (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[0] : m_ie;
                        m_ie    <= 1'b0;
                        m_phase <= 2;
                    end else if (cfg_we && cfg_addr == 2'd2) begin
                        m_ie <= cfg_wdata[0];
                    end
                end
                default: begin
                    if (cfg_we && cfg_addr == 2'd2) m_ie_sv <= cfg_wdata[0];
                    if (intr_done) begin
                        m_ie    <= (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[0] : m_ie_sv;
                        m_phase <= 0;
                    end
                end
            endcase
        end
    end

    function automatic logic [1:0] exp_intr();
        if (m_phase != 1) return 2'b00;
        return (m_line == 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] exp_rd();
        case (cfg_addr)
            2'd0:    return {4'h0, m_mask};
            2'd1:    return {4'h0, cur_pend()};
            2'd2:    return {7'h00, m_ie};
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_intr", {6'b0, INTR}, {6'b0, exp_intr()});
            chk("model_vec", intr_vec, m_vec);
            chk("model_rdata", cfg_rdata, exp_rd());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        intr_ack  = 1'b0;
        intr_done = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'(cyc % 4);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        $display("cfg write addr=%0d data=%h", a, d);
    endtask

    task automatic read_cfg(input logic [1:0] a, output logic [7:0] v);
        cfg_addr = a;
        #1;
        v = cfg_rdata;
    endtask

    task automatic pulse_ack();
        intr_ack = 1'b1;
        tick();
        $display("ack   INTR=%b vec=%h", INTR, intr_vec);
    endtask

    task automatic pulse_done();
        intr_done = 1'b1;
        tick();
        $display("done  INTR=%b vec=%h", INTR, intr_vec);
    endtask

    task automatic wait_intr(output int n);
        n = 0;
        while (INTR == 2'b00 && n < 8) begin
            tick();
            n++;
        end
        $display("req   INTR=%b vec=%h after %0d cycles", INTR, intr_vec, n);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int         n;
        logic [7:0] v;

        rst = 1'b1; irq = 4'h0; intr_ack = 1'b0; intr_done = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_intr", {6'b0, INTR}, 8'h00);
        chk("reset_vec", intr_vec, 8'h00);

        // Stray handshakes while idle must be ignored.
        pulse_ack();
        pulse_done();
        chk("stray_intr", {6'b0, INTR}, 8'h00);

        // 1: maskable line 2
        cfg_write(2'd0, 8'h0E);
        cfg_write(2'd2, 8'h01);
        irq[2] = 1'b1;
        wait_intr(n);
        chk("s1_latency", 8'(n), 8'(LAT));
        chk("s1_intr", {6'b0, INTR}, 8'h01);
        chk("s1_vec", intr_vec, 8'hF4);
        pulse_ack();
        chk("s1_ack_intr", {6'b0, INTR}, 8'h00);
        irq[2] = 1'b0; tick();
        pulse_done();
        idle(2);

        // 2: NMI with everything masked
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd2, 8'h00);
        irq[0] = 1'b1;
        wait_intr(n);
        chk("s2_intr", {6'b0, INTR}, 8'h02);
        chk("s2_vec", intr_vec, 8'hF0);
        pulse_ack();
        irq[0] = 1'b0; tick();
        read_cfg(2'd1, v);
        chk("s2_pend_after_ack", v, 8'h00);
        pulse_done();
        idle(2);
        chk("s2_idle_intr", {6'b0, INTR}, 8'h00);

        // 3: simultaneous lines 3 and 1, line 1 first
        cfg_write(2'd0, 8'h0E);
        cfg_write(2'd2, 8'h01);
        irq[3] = 1'b1; irq[1] = 1'b1;
        wait_intr(n);
        chk("s3_first_vec", intr_vec, 8'hF2);
        pulse_ack();
        irq[1] = 1'b0; tick();
        pulse_done();
        wait_intr(n);
        chk("s3_second_vec", intr_vec, 8'hF6);
        chk("s3_second_intr", {6'b0, INTR}, 8'h01);
        pulse_ack();
        irq[3] = 1'b0; tick();
        pulse_done();
        idle(2);

        // 4: higher-priority line arrives while line 3 is requested
        irq[3] = 1'b1;
        wait_intr(n);
        chk("s4_vec", intr_vec, 8'hF6);
        irq[1] = 1'b1;
        idle(2);
        chk("s4_no_rearb_vec", intr_vec, 8'hF6);
        chk("s4_no_rearb_intr", {6'b0, INTR}, 8'h01);
        pulse_ack();
        irq[3] = 1'b0; tick();
        chk("s4_held_vec", intr_vec, 8'hF6);
        pulse_done();
        wait_intr(n);
        chk("s4_next_vec", intr_vec, 8'hF2);
        pulse_ack();
        irq[1] = 1'b0; tick();
        pulse_done();
        idle(2);

        // 5: IE cleared from inside the handler
        irq[2] = 1'b1;
        wait_intr(n);
        chk("s5_vec", intr_vec, 8'hF4);
        pulse_ack();
        cfg_write(2'd2, 8'h00);
        irq[2] = 1'b0; tick();
        irq[2] = 1'b1; tick();
        pulse_done();
        idle(3);
        chk("s5_not_requested", {6'b0, INTR}, 8'h00);
        read_cfg(2'd2, v);
        chk("s5_ie_after_done", v, 8'h00);
        read_cfg(2'd1, v);
        chk("s5_pend_line2", v, 8'h04);
        cfg_write(2'd1, 8'h04);
        read_cfg(2'd1, v);
        chk("s5_pend_w1c", v, EDGE ? 8'h00 : 8'h04);
        irq[2] = 1'b0; tick();
        cfg_write(2'd2, 8'h01);
        idle(2);
        chk("s5_idle_intr", {6'b0, INTR}, 8'h00);

        // 7: NMI raised during a maskable handler waits for RETI
        irq[1] = 1'b1;
        wait_intr(n);
        chk("s7_vec", intr_vec, 8'hF2);
        pulse_ack();
        irq[0] = 1'b1;
        idle(2);
        chk("s7_nmi_waits", {6'b0, INTR}, 8'h00);
        irq[1] = 1'b0; tick();
        pulse_done();
        wait_intr(n);
        chk("s7_nmi_intr", {6'b0, INTR}, 8'h02);
        chk("s7_nmi_vec", intr_vec, 8'hF0);
        pulse_ack();
        irq[0] = 1'b0; tick();
        pulse_done();
        idle(2);

        // 6: reset while a request is outstanding
        irq[2] = 1'b1;
        wait_intr(n);
        chk("s6_pre_intr", {6'b0, INTR}, 8'h01);
        rst = 1'b1; irq = 4'h0;
        tick();
        rst = 1'b0;
        chk("s6_intr", {6'b0, INTR}, 8'h00);
        chk("s6_vec", intr_vec, 8'h00);
        read_cfg(2'd0, v);
        chk("s6_mask", v, 8'h00);
        read_cfg(2'd1, v);
        chk("s6_pend", v, 8'h00);
        read_cfg(2'd2, v);
        chk("s6_ie", v, 8'h00);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
